// File: rtl/cdb_arbiter.sv
// cdb_arbiter: producer end of the common data bus.
// Each functional unit parks a finished result (tag + data) in its own
// one-entry capture slot; a round-robin grant broadcasts one slot per cycle
// on cdb_id / cdb_data, which every reservation station snoops.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   src_req      per-source request, sampled on the rising edge
//   src_tag      per-source RS tag, source i at [i*TAG_W +: TAG_W]
//   src_data     per-source result, source i at [i*DATA_W +: DATA_W]
//   src_ack      one-cycle pulse: request captured on the previous edge
//   src_full     slot i holds a result not yet broadcast
//   cdb_valid    broadcast valid this cycle
//   cdb_id       broadcast tag (0 when idle)
//   cdb_data     broadcast data (0 when idle)
//   cdb_src      index of the winning source (holds when idle)
//   tag_err      sticky: a request arrived with tag 0
//
// Optional feature (macro CDB_STATS_EN):
//   bcast_cnt    32-bit count of broadcast edges
//   stall_cnt    32-bit count of edges where a nonzero-tag request was refused
//                because its slot was full

module cdb_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DATA_W  = 64,
    localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [TAG_W*NUM_SRC-1:0]  src_tag,
    input  logic [DATA_W*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ack,
    output logic [NUM_SRC-1:0]        src_full,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_id,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src,
    output logic                      tag_err
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]               bcast_cnt,
    output logic [31:0]               stall_cnt
`endif
);

    logic [NUM_SRC-1:0] slot_vld;
    logic [TAG_W-1:0]   slot_tag  [NUM_SRC];
    logic [DATA_W-1:0]  slot_data [NUM_SRC];
    logic [SRC_W-1:0]   rr_ptr;

    logic               grant_vld_c;
    logic [SRC_W-1:0]   grant_idx_c;
    logic [SRC_W-1:0]   rr_next_c;
    logic [NUM_SRC-1:0] tag_nz_c;
    logic [NUM_SRC-1:0] drain_c;
    logic [NUM_SRC-1:0] accept_c;

    // Round-robin search over the pre-edge slot contents, starting at rr_ptr.
    always_comb begin
        int unsigned idx;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_SRC;
            if (!grant_vld_c && slot_vld[SRC_W'(idx)]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = SRC_W'(idx);
            end
        end
    end

    assign rr_next_c = (32'(grant_idx_c) == NUM_SRC - 1) ? '0 : grant_idx_c + 1'b1;

    // A slot accepts when empty, or when it is being drained on this same edge.
    always_comb begin
        tag_nz_c = '0;
        drain_c  = '0;
        accept_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            tag_nz_c[i] = |src_tag[i*TAG_W +: TAG_W];
            drain_c[i]  = grant_vld_c && (grant_idx_c == SRC_W'(i));
            accept_c[i] = src_req[i] && tag_nz_c[i] && (!slot_vld[i] || drain_c[i]);
        end
    end

    // Slot capture/drain, broadcast register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld  <= '0;
            rr_ptr    <= '0;
            src_ack   <= '0;
            cdb_valid <= 1'b0;
            cdb_id    <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            tag_err   <= 1'b0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                slot_tag[i]  <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            src_ack   <= accept_c;
            tag_err   <= tag_err | (|(src_req & ~tag_nz_c));
            cdb_valid <= grant_vld_c;
            if (grant_vld_c) begin
                cdb_id   <= slot_tag[grant_idx_c];
                cdb_data <= slot_data[grant_idx_c];
                cdb_src  <= grant_idx_c;
                rr_ptr   <= rr_next_c;
            end else begin
                cdb_id   <= '0;
                cdb_data <= '0;
            end
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (accept_c[i]) begin
                    slot_vld[i]  <= 1'b1;
                    slot_tag[i]  <= src_tag[i*TAG_W +: TAG_W];
                    slot_data[i] <= src_data[i*DATA_W +: DATA_W];
                end else if (drain_c[i]) begin
                    slot_vld[i]  <= 1'b0;
                end
            end
        end
    end

    assign src_full = slot_vld;

`ifdef CDB_STATS_EN
    logic refuse_c;

    // One stall count per edge with at least one refused nonzero-tag request.
    assign refuse_c = |(src_req & tag_nz_c & ~accept_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcast_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (grant_vld_c) bcast_cnt <= bcast_cnt + 32'd1;
            if (refuse_c)    stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a slot/queue reference model.
module tb_cdb_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TW = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    src_req;
    logic [TW*N-1:0] src_tag;
    logic [DW*N-1:0] src_data;
    logic [N-1:0]    src_ack;
    logic [N-1:0]    src_full;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_id;
    logic [DW-1:0]   cdb_data;
    logic [SW-1:0]   cdb_src;
    logic            tag_err;
`ifdef CDB_STATS_EN
    logic [31:0]     bcast_cnt;
    logic [31:0]     stall_cnt;
`endif

    cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_req   (src_req),
        .src_tag   (src_tag),
        .src_data  (src_data),
        .src_ack   (src_ack),
        .src_full  (src_full),
        .cdb_valid (cdb_valid),
        .cdb_id    (cdb_id),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .tag_err   (tag_err)
`ifdef CDB_STATS_EN
        ,
        .bcast_cnt (bcast_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int vecs = 0;
    int errs = 0;

    // Reference model: parked results per source plus the round-robin pointer.
    logic [N-1:0]  m_vld;
    logic [TW-1:0] m_tag  [N];
    logic [DW-1:0] m_data [N];
    int            m_rr;
    logic [N-1:0]  e_ack;
    logic          e_valid;
    logic [TW-1:0] e_id;
    logic [DW-1:0] e_data;
    logic [SW-1:0] e_src;
    logic          e_err;
    logic [31:0]   e_bcast;
    logic [31:0]   e_stall;

    // Source-side driver state: a pending result is held until acked.
    logic [N-1:0]  p_req;
    logic [TW-1:0] p_tag  [N];
    logic [DW-1:0] p_data [N];

    logic [79:0] got_v, exp_v;

    task automatic model_reset();
        m_vld = '0; m_rr = 0; e_ack = '0; e_valid = 1'b0; e_id = '0;
        e_data = '0; e_src = '0; e_err = 1'b0; e_bcast = '0; e_stall = '0;
        for (int i = 0; i < N; i++) begin m_tag[i] = '0; m_data[i] = '0; end
    endtask

    // One clock edge of the model: broadcast oldest-in-rotation, then capture.
    task automatic model_edge();
        int  win;
        logic refused;
        if (!rst_n) return;
        win = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && m_vld[(m_rr + k) % N]) win = (m_rr + k) % N;
        if (win >= 0) begin
            e_valid = 1'b1; e_id = m_tag[win]; e_data = m_data[win];
            e_src = SW'(win); m_vld[win] = 1'b0; m_rr = (win + 1) % N;
            e_bcast = e_bcast + 32'd1;
        end else begin
            e_valid = 1'b0; e_id = '0; e_data = '0;
        end
        refused = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_ack[i] = 1'b0;
            if (src_req[i]) begin
                if (src_tag[i*TW +: TW] == '0) e_err = 1'b1;
                else if (!m_vld[i]) begin
                    m_vld[i] = 1'b1; m_tag[i] = src_tag[i*TW +: TW];
                    m_data[i] = src_data[i*DW +: DW]; e_ack[i] = 1'b1;
                end else refused = 1'b1;
            end
        end
        if (refused) e_stall = e_stall + 32'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        got_v = {src_ack, src_full, cdb_valid, cdb_id, cdb_data, cdb_src, tag_err};
        exp_v = {e_ack, m_vld, e_valid, e_id, e_data, e_src, e_err};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_req = '0; src_tag = '0; src_data = '0; p_req = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply_src();
        for (int i = 0; i < N; i++) begin
            src_req[i] = p_req[i];
            src_tag[i*TW +: TW] = p_tag[i];
            src_data[i*DW +: DW] = p_data[i];
        end
    endtask

    // Retire acked results and start new ones (forced sources always busy).
    task automatic update_src(input logic [N-1:0] force_m, input int pct, input logic [N-1:0] en_m);
        for (int i = 0; i < N; i++) begin
            if (!en_m[i]) p_req[i] = 1'b0;
            else begin
                if (p_req[i] && e_ack[i]) p_req[i] = 1'b0;
                if (!p_req[i] && (force_m[i] || $urandom_range(99) < pct)) begin
                    p_req[i] = 1'b1;
                    p_tag[i] = TW'($urandom_range(15, 1));
                    p_data[i] = {$urandom, $urandom};
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({src_ack, src_full, cdb_valid, cdb_id, cdb_data, cdb_src, tag_err} !== 80'd0) begin
            errs++;
            $display("FAIL reset_state: got ack=%b full=%b v=%b id=%h src=%0d err=%b, want all 0",
                     src_ack, src_full, cdb_valid, cdb_id, cdb_src, tag_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vecs++;
        if (cdb_valid !== 1'b0 || src_full !== 4'b0) begin
            errs++;
            $display("FAIL reset_idle: got valid=%b full=%b, want 0 0000", cdb_valid, src_full);
        end
    endtask

    task automatic test_single();
        do_reset();
        src_req = 4'b0001; src_tag[3:0] = 4'd1; src_data[63:0] = 64'hA5;
        tick();
        vecs++;
        if (src_ack !== 4'b0001 || src_full !== 4'b0001 || cdb_valid !== 1'b0) begin
            errs++;
            $display("FAIL single_ack: got ack=%b full=%b valid=%b, want 0001 0001 0", src_ack, src_full, cdb_valid);
        end
        src_req = '0;
        tick();
        vecs++;
        if (cdb_valid !== 1'b1 || cdb_id !== 4'd1 || cdb_data !== 64'hA5 || cdb_src !== 2'd0 || src_ack !== 4'b0) begin
            errs++;
            $display("FAIL single_bcast: got v=%b id=%0d data=%h src=%0d ack=%b, want 1 1 a5 0 0000",
                     cdb_valid, cdb_id, cdb_data, cdb_src, src_ack);
        end
        tick();
        vecs++;
        if (cdb_valid !== 1'b0 || cdb_id !== 4'd0 || cdb_data !== 64'd0) begin
            errs++;
            $display("FAIL single_idle: got v=%b id=%0d data=%h, want 0 0 0", cdb_valid, cdb_id, cdb_data);
        end
    endtask

    task automatic test_contention();
        logic [TW-1:0] tags [N];
        tags[0] = 4'd1; tags[1] = 4'd4; tags[2] = 4'd6; tags[3] = 4'd9;
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_tag[i*TW +: TW] = tags[i]; src_data[i*DW +: DW] = DW'(100 + i);
        end
        src_req = 4'b1111;
        tick();
        src_req = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            vecs++;
            if (cdb_valid !== 1'b1 || cdb_id !== tags[k] || cdb_src !== SW'(k) || cdb_data !== DW'(100 + k)) begin
                errs++;
                $display("FAIL contention_order[%0d]: got v=%b id=%0d src=%0d data=%0d, want 1 %0d %0d %0d",
                         k, cdb_valid, cdb_id, cdb_src, cdb_data, tags[k], k, 100 + k);
            end
        end
        src_tag = {4'd7, 4'd5, 4'd3, 4'd2};
        src_req = 4'b1111;
        tick();
        src_req = '0;
        tick();
        vecs++;
        if (cdb_src !== 2'd0 || cdb_id !== 4'd2) begin
            errs++;
            $display("FAIL contention_wrap: got src=%0d id=%0d, want 0 2", cdb_src, cdb_id);
        end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] tags [3];
        tags[0] = 4'd2; tags[1] = 4'd3; tags[2] = 4'd2;
        do_reset();
        src_req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin src_tag[7:4] = tags[k]; src_data[127:64] = DW'(10 + k); end
            else src_req = '0;
            tick();
            vecs++;
            if (k < 3 && (src_ack !== 4'b0010 || src_full[1] !== 1'b1)) begin
                errs++;
                $display("FAIL b2b_ack[%0d]: got ack=%b full=%b, want 0010 with full[1]=1", k, src_ack, src_full);
            end else if (k > 0 && (cdb_valid !== 1'b1 || cdb_id !== tags[k-1] || cdb_data !== DW'(9 + k))) begin
                errs++;
                $display("FAIL b2b_bcast[%0d]: got v=%b id=%0d data=%0d, want 1 %0d %0d",
                         k, cdb_valid, cdb_id, cdb_data, tags[k-1], 9 + k);
            end
        end
    endtask

    task automatic test_backpressure();
        int held_no_ack;
        held_no_ack = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            update_src(4'b0111, 0, 4'b0111);
            apply_src();
            tick();
            if (src_req[2] && !src_ack[2]) held_no_ack++;
            vecs++;
            if (got_v !== exp_v) begin
                errs++;
                $display("FAIL backpressure[%0d]: got %h want %h", c, got_v, exp_v);
            end
        end
        vecs++;
        if (held_no_ack == 0) begin
            errs++;
            $display("FAIL backpressure_stall: got 0 refused cycles on source 2, want >0");
        end
`ifdef CDB_STATS_EN
        vecs++;
        if (stall_cnt !== e_stall || bcast_cnt !== e_bcast) begin
            errs++;
            $display("FAIL stats_bp: got stall=%0d bcast=%0d want %0d %0d", stall_cnt, bcast_cnt, e_stall, e_bcast);
        end
`endif
    endtask

    task automatic test_tag0();
        do_reset();
        src_req = 4'b1000; src_tag[15:12] = 4'd0; src_data[255:192] = 64'd5;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) src_req = '0;
            tick();
            vecs++;
            if (src_ack !== 4'b0 || src_full !== 4'b0 || cdb_valid !== 1'b0 || tag_err !== 1'b1) begin
                errs++;
                $display("FAIL tag0[%0d]: got ack=%b full=%b v=%b err=%b, want 0000 0000 0 1",
                         c, src_ack, src_full, cdb_valid, tag_err);
            end
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (tag_err !== 1'b0) begin
            errs++;
            $display("FAIL tag0_clear: got err=%b want 0", tag_err);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        src_tag = {4'd8, 4'd7, 4'd5, 4'd3};
        src_req = 4'b1111;
        tick();
        src_req = '0;
        tick();
        vecs++;
        if (cdb_valid !== 1'b1 || src_full !== 4'b1110) begin
            errs++;
            $display("FAIL midrst_pre: got v=%b full=%b want 1 1110", cdb_valid, src_full);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vecs++;
        if ({src_ack, src_full, cdb_valid, cdb_id, cdb_data, cdb_src} !== 79'd0) begin
            errs++;
            $display("FAIL midrst_async: got ack=%b full=%b v=%b id=%0d src=%0d want all 0",
                     src_ack, src_full, cdb_valid, cdb_id, cdb_src);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            vecs++;
            if (cdb_valid !== 1'b0 || src_full !== 4'b0) begin
                errs++;
                $display("FAIL midrst_after[%0d]: got v=%b full=%b want 0 0000", c, cdb_valid, src_full);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            update_src(4'b0000, (c < 200) ? 60 : 25, 4'b1111);
            apply_src();
            tick();
            vecs++;
            if (got_v !== exp_v) begin
                errs++;
                $display("FAIL random[%0d]: got %h want %h", c, got_v, exp_v);
            end
        end
`ifdef CDB_STATS_EN
        vecs++;
        if (stall_cnt !== e_stall || bcast_cnt !== e_bcast) begin
            errs++;
            $display("FAIL stats_rand: got stall=%0d bcast=%0d want %0d %0d", stall_cnt, bcast_cnt, e_stall, e_bcast);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_backpressure();
        test_tag0();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
